// File: rtl/trainer_pkg.sv
// Shared widths, state encoding and helpers for the trainer and its associator.
package trainer_pkg;

    localparam int unsigned DEF_ARG_DEPTH = 2;
    localparam int unsigned DEF_ARG_WIDTH = 8;
    localparam int unsigned DEF_RES_WIDTH = 16;
    localparam int unsigned DEF_ERR_WIDTH = 16;
    localparam int unsigned DEF_FBK_DEPTH = 2;
    localparam int unsigned DEF_FBK_WIDTH = 16;
    localparam int unsigned DEF_SETS      = 4;
    localparam int unsigned DEF_EPOCHS    = 25;
    localparam logic [15:0] DEF_HIGH      = 16'h00ff;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] S_FWD     = 3'd1;
    localparam logic [STATE_W-1:0] S_RES     = 3'd2;
    localparam logic [STATE_W-1:0] S_BWD     = 3'd3;
    localparam logic [STATE_W-1:0] S_FBK     = 3'd4;
    localparam logic [STATE_W-1:0] S_CHK_FWD = 3'd5;
    localparam logic [STATE_W-1:0] S_CHK_RES = 3'd6;
    localparam logic [STATE_W-1:0] S_DONE    = 3'd7;

    // Address width for an n-entry structure, never below one bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trainer_table.sv
// Sample table: register file with one write port and one combinational read port.
module trainer_table
    import trainer_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_SETS,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = addr_width(DEPTH)
)(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/trainer.sv
// Trainer: drives an associator through EPOCHS learning passes over a sample
// table, then runs one check pass and reports the number of mismatches.
module trainer
    import trainer_pkg::*;
#(
    parameter int unsigned ARG_DEPTH = DEF_ARG_DEPTH,
    parameter int unsigned ARG_WIDTH = DEF_ARG_WIDTH,
    parameter int unsigned RES_WIDTH = DEF_RES_WIDTH,
    parameter int unsigned ERR_WIDTH = DEF_ERR_WIDTH,
    parameter int unsigned FBK_DEPTH = DEF_FBK_DEPTH,
    parameter int unsigned FBK_WIDTH = DEF_FBK_WIDTH,
    parameter int unsigned SETS      = DEF_SETS,
    parameter int unsigned EPOCHS    = DEF_EPOCHS,
    parameter logic [RES_WIDTH-1:0] HIGH = RES_WIDTH'(DEF_HIGH)
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           set_valid,
    output logic                           set_ready,
    input  logic [ARG_DEPTH*ARG_WIDTH-1:0] set_arg,
    input  logic [RES_WIDTH-1:0]           set_tgt,
    input  logic                           start,
    output logic                           arg_valid,
    input  logic                           arg_ready,
    output logic [ARG_DEPTH*ARG_WIDTH-1:0] arg_data,
    input  logic                           res_valid,
    output logic                           res_ready,
    input  logic [RES_WIDTH-1:0]           res_data,
    output logic                           err_valid,
    input  logic                           err_ready,
    output logic [ERR_WIDTH-1:0]           err_data,
    input  logic                           fbk_valid,
    output logic                           fbk_ready,
    input  logic [FBK_DEPTH*FBK_WIDTH-1:0] fbk_data,
    output logic                           en,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(SETS+1)-1:0]      misses
);

    localparam int unsigned ARG_W  = ARG_DEPTH * ARG_WIDTH;
    localparam int unsigned WORD_W = ARG_W + RES_WIDTH;
    localparam int unsigned IDX_W  = addr_width(SETS);
    localparam int unsigned EP_W   = addr_width(EPOCHS);
    localparam int unsigned MISS_W = $clog2(SETS + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(SETS - 1);
    localparam logic [EP_W-1:0]  LAST_EPOCH = EP_W'(EPOCHS - 1);

    logic [STATE_W-1:0]   state_q, state_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic [IDX_W-1:0]     wptr_q;
    logic [EP_W-1:0]      epoch_q, epoch_d;
    logic [MISS_W-1:0]    misses_d;
    logic [ERR_WIDTH-1:0] err_d;
    logic [RES_WIDTH-1:0] tgt_q;
    logic [RES_WIDTH-1:0] act;
    logic [RES_WIDTH:0]   diff;
    logic                 wr_en;
    logic [WORD_W-1:0]    wr_word;
    logic [WORD_W-1:0]    tbl_word;
    logic [WORD_W-1:0]    rd_word;
    logic                 load_sample;
    logic                 unused_fbk;

    // Feedback payload is consumed by the handshake only.
    assign unused_fbk = ^fbk_data;

    assign wr_en   = set_valid && set_ready;
    assign wr_word = {set_arg, set_tgt};

    trainer_table #(
        .DEPTH  (SETS),
        .DATA_W (WORD_W),
        .ADDR_W (IDX_W)
    ) u_table (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_addr   (wptr_q),
        .wr_data   (wr_word),
        .rd_addr   (index_d),
        .rd_data_c (tbl_word)
    );

    // Forward a same-cycle write so start together with a write sees fresh data.
    assign rd_word     = (wr_en && (wptr_q == index_d)) ? wr_word : tbl_word;
    assign load_sample = (state_d == S_FWD) || (state_d == S_CHK_FWD);

    // Next state, sample index and epoch.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        epoch_d = epoch_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    index_d = '0;
                    epoch_d = '0;
                    state_d = S_FWD;
                end
            end
            S_FWD: begin
                if (arg_valid && arg_ready) state_d = S_RES;
            end
            S_RES: begin
                if (res_ready && res_valid) state_d = S_BWD;
            end
            S_BWD: begin
                if (err_valid && err_ready) state_d = S_FBK;
            end
            S_FBK: begin
                if (fbk_ready && fbk_valid) begin
                    if (index_q != LAST_IDX) begin
                        index_d = index_q + IDX_W'(1);
                        state_d = S_FWD;
                    end else begin
                        index_d = '0;
                        if (epoch_q != LAST_EPOCH) begin
                            epoch_d = epoch_q + EP_W'(1);
                            state_d = S_FWD;
                        end else begin
                            state_d = S_CHK_FWD;
                        end
                    end
                end
            end
            S_CHK_FWD: begin
                if (arg_valid && arg_ready) state_d = S_CHK_RES;
            end
            S_CHK_RES: begin
                if (res_ready && res_valid) begin
                    if (index_q != LAST_IDX) begin
                        index_d = index_q + IDX_W'(1);
                        state_d = S_CHK_FWD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Error from the thresholded result, and mismatch counting in the check pass.
    always_comb begin
        err_d    = err_data;
        misses_d = misses;
        act      = res_data[RES_WIDTH-1] ? '0 : HIGH;
        diff     = {tgt_q[RES_WIDTH-1], tgt_q} - {act[RES_WIDTH-1], act};
        if ((state_q == S_IDLE) && start) begin
            misses_d = '0;
        end
        if (res_ready && res_valid) begin
            err_d = ERR_WIDTH'($signed(diff));
            if ((state_q == S_CHK_RES) && (err_d != '0)) begin
                misses_d = misses + MISS_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: pointers, counters, current sample and error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q  <= '0;
            epoch_q  <= '0;
            wptr_q   <= '0;
            misses   <= '0;
            err_data <= '0;
            tgt_q    <= '0;
            arg_data <= '0;
        end else begin
            index_q  <= index_d;
            epoch_q  <= epoch_d;
            misses   <= misses_d;
            err_data <= err_d;
            if (wr_en) begin
                wptr_q <= (wptr_q == LAST_IDX) ? '0 : wptr_q + IDX_W'(1);
            end
            if (load_sample) begin
                arg_data <= rd_word[WORD_W-1 -: ARG_W];
                tgt_q    <= rd_word[RES_WIDTH-1:0];
            end
        end
    end

    // Handshake and status outputs, registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_ready <= 1'b1;
            arg_valid <= 1'b0;
            res_ready <= 1'b0;
            err_valid <= 1'b0;
            fbk_ready <= 1'b0;
            en        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            set_ready <= (state_d == S_IDLE);
            arg_valid <= load_sample;
            res_ready <= (state_d == S_RES) || (state_d == S_CHK_RES);
            err_valid <= (state_d == S_BWD);
            fbk_ready <= (state_d == S_FBK);
            en        <= (state_d == S_FWD) || (state_d == S_RES) ||
                         (state_d == S_BWD) || (state_d == S_FBK);
            busy      <= (state_d != S_IDLE) && (state_d != S_DONE);
            done      <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_trainer.sv
// Self-checking bench for trainer: a bench-side associator answers with
// randomized stalls while a scoreboard predicts every transfer and the result.
module tb_trainer;

    localparam int SETS   = 4;
    localparam int EPOCHS = 25;
    localparam int TRAIN  = SETS * EPOCHS;
    localparam logic [15:0] HIGH = 16'h00ff;
    localparam int M_PERC = 0;
    localparam int M_ZERO = 1;
    localparam int M_RAND = 2;
    localparam int BUDGET = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_valid, set_ready, start;
    logic [15:0] set_arg, set_tgt;
    logic        arg_valid, arg_ready;
    logic [15:0] arg_data;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic        err_valid, err_ready;
    logic [15:0] err_data;
    logic        fbk_valid, fbk_ready;
    logic [31:0] fbk_data;
    logic        en, busy, done;
    logic [2:0]  misses;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mdl_arg [SETS];
    logic [15:0] mdl_tgt [SETS];
    int          mdl_wptr = 0;

    trainer dut (
        .clk       (clk),
        .rst       (rst),
        .set_valid (set_valid),
        .set_ready (set_ready),
        .set_arg   (set_arg),
        .set_tgt   (set_tgt),
        .start     (start),
        .arg_valid (arg_valid),
        .arg_ready (arg_ready),
        .arg_data  (arg_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .err_valid (err_valid),
        .err_ready (err_ready),
        .err_data  (err_data),
        .fbk_valid (fbk_valid),
        .fbk_ready (fbk_ready),
        .fbk_data  (fbk_data),
        .en        (en),
        .busy      (busy),
        .done      (done),
        .misses    (misses)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_sample(input logic [15:0] a, input logic [15:0] t, input bit with_start);
        @(negedge clk);
        set_valid = 1'b1;
        set_arg   = a;
        set_tgt   = t;
        start     = with_start;
        mdl_arg[mdl_wptr] = a;
        mdl_tgt[mdl_wptr] = t;
        mdl_wptr = (mdl_wptr + 1) % SETS;
        if (!with_start) begin
            @(negedge clk);
            set_valid = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        set_valid = 1'b0; start = 1'b0;
        arg_ready = 1'b0; res_valid = 1'b0; err_ready = 1'b0; fbk_valid = 1'b0;
    endtask

    // One complete run; the associator model and scoreboard live here.
    task automatic run_training(input int mode, input bit inject, input bit self_start,
                                input int want_misses, input string name);
        int fwd_n = 0, res_n = 0, err_n = 0, fbk_n = 0, miss_exp = 0, cyc = 0;
        int onehot_bad = 0, wr_bad = 0, cur_idx = 0;
        int w0 = 0, w1 = 0, b = 0, sum;
        bit res_pend = 0, fbk_pend = 0, done_seen = 0;
        logic [15:0] res_q = '0, err_exp_q = '0, act, e;
        if (self_start) begin
            @(negedge clk);
            start = 1'b1;
        end
        while (!done_seen && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (32'(arg_valid) + 32'(res_ready) + 32'(err_valid) + 32'(fbk_ready) > 1) onehot_bad++;
            if (done) begin
                done_seen = 1;
                idle_inputs();
                check_eq({name, "_misses"}, 32'(misses), miss_exp);
                if (want_misses >= 0) check_eq({name, "_misses_req"}, 32'(misses), want_misses);
                check_eq({name, "_busy_at_done"}, 32'(busy), 0);
                check_eq({name, "_en_at_done"}, 32'(en), 0);
                check_eq({name, "_fwd_count"}, fwd_n, TRAIN + SETS);
                check_eq({name, "_res_count"}, res_n, TRAIN + SETS);
                check_eq({name, "_err_count"}, err_n, TRAIN);
                check_eq({name, "_fbk_count"}, fbk_n, TRAIN);
                check_eq({name, "_onehot"}, onehot_bad, 0);
                if (inject) check_eq({name, "_write_blocked"}, wr_bad, 0);
                break;
            end
            // Control stimulus: optionally hammer start and set_valid during the run.
            start     = inject && busy;
            set_valid = inject && busy && ($urandom_range(0, 3) == 0);
            set_arg   = 16'($urandom);
            set_tgt   = 16'($urandom);
            if (set_valid && set_ready) wr_bad++;
            // Associator side, with random stalls; valid holds until its transfer.
            arg_ready = ($urandom_range(0, 3) != 0);
            err_ready = ($urandom_range(0, 2) != 0);
            if (!res_pend) res_valid = 1'b0;
            else if (!res_valid) res_valid = ($urandom_range(0, 2) != 0);
            res_data = res_q;
            if (!fbk_pend) fbk_valid = 1'b0;
            else if (!fbk_valid) begin
                fbk_valid = ($urandom_range(0, 1) == 1);
                fbk_data  = $urandom;
            end
            // Transfers that occur on the coming rising edge.
            if (arg_valid && arg_ready) begin
                cur_idx = fwd_n % SETS;
                check_eq({name, "_arg_data"}, 32'(arg_data), 32'(mdl_arg[cur_idx]));
                check_eq({name, "_arg_en"}, 32'(en), 32'(fwd_n < TRAIN));
                fwd_n++;
                case (mode)
                    M_PERC: begin
                        sum = b + ((arg_data[7:0] != 0) ? w0 : 0) + ((arg_data[15:8] != 0) ? w1 : 0);
                        res_q = sum[15:0];
                    end
                    M_ZERO:  res_q = 16'h0000;
                    default: res_q = 16'($urandom);
                endcase
                res_pend = 1;
            end
            if (res_ready && res_valid) begin
                act = res_data[15] ? 16'h0000 : HIGH;
                e   = mdl_tgt[cur_idx] - act;
                if (fwd_n > TRAIN) begin
                    if (e != 0) miss_exp++;
                end else begin
                    err_exp_q = e;
                end
                res_pend = 0;
                res_n++;
            end
            if (err_valid && err_ready) begin
                check_eq({name, "_err_data"}, 32'(err_data), 32'(err_exp_q));
                check_eq({name, "_err_en"}, 32'(en), 1);
                if (mode == M_ZERO && err_n < SETS)
                    check_eq({name, "_stub_err"}, 32'(err_data), (cur_idx == 3) ? 0 : 32'h0000ff01);
                if (mode == M_PERC && err_exp_q != 0) begin
                    if ($signed(err_exp_q) > 0) begin
                        b++;
                        if (arg_data[7:0] != 0) w0++;
                        if (arg_data[15:8] != 0) w1++;
                    end else begin
                        b--;
                        if (arg_data[7:0] != 0) w0--;
                        if (arg_data[15:8] != 0) w1--;
                    end
                end
                fbk_pend = 1;
                err_n++;
            end
            if (fbk_valid && fbk_ready) begin
                fbk_pend = 0;
                fbk_n++;
            end
        end
        idle_inputs();
        if (!done_seen) begin
            check_eq({name, "_timeout"}, 0, 1);
        end else begin
            @(negedge clk);
            check_eq({name, "_done_pulse"}, 32'(done), 0);
            check_eq({name, "_set_ready_after"}, 32'(set_ready), 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        set_arg = '0; set_tgt = '0; res_data = '0; fbk_data = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_set_ready", 32'(set_ready), 1);
        check_eq("rst_arg_valid", 32'(arg_valid), 0);
        check_eq("rst_res_ready", 32'(res_ready), 0);
        check_eq("rst_busy_en_done", {29'd0, busy, en, done}, 0);
        check_eq("rst_misses", 32'(misses), 0);
        check_eq("rst_err_data", 32'(err_data), 0);
        rst = 1'b0;
        mdl_wptr = 0;

        // AND set, last write together with start, start/set_valid hammered mid-run.
        load_sample(16'h0000, 16'h0000, 0);
        load_sample(16'h00ff, 16'h0000, 0);
        load_sample(16'hff00, 16'h0000, 0);
        load_sample(16'hffff, 16'h00ff, 1);
        run_training(M_PERC, 1, 0, 0, "and");

        // Stub responder on the untouched AND table.
        run_training(M_ZERO, 0, 1, 3, "stub");

        // OR set.
        load_sample(16'h0000, 16'h0000, 0);
        load_sample(16'h00ff, 16'h00ff, 0);
        load_sample(16'hff00, 16'h00ff, 0);
        load_sample(16'hffff, 16'h00ff, 0);
        run_training(M_PERC, 0, 1, 0, "or");

        // Random sample written to the entry read first, in the start cycle.
        load_sample(16'($urandom), 16'($urandom), 1);
        run_training(M_RAND, 0, 0, -1, "rnd_bypass");

        for (int i = 0; i < SETS; i++) load_sample(16'($urandom), 16'($urandom), 0);
        run_training(M_RAND, 0, 1, -1, "rnd");

        // Reset in the middle of FWD.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        arg_ready = 1'b0;
        check_eq("pre_rst_arg_valid", 32'(arg_valid), 1);
        rst = 1'b1;
        #1;
        check_eq("midrst_arg_valid", 32'(arg_valid), 0);
        check_eq("midrst_en", 32'(en), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        mdl_wptr = 0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_set_ready", 32'(set_ready), 1);
        check_eq("post_rst_busy_done", {30'd0, busy, done}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
